// File: rtl/any1_wb_dnsize.sv
// any1_wb_dnsize: 128-bit to 32-bit Wishbone classic-cycle downsizing bridge.
//
// Each 128-bit request is split into one 32-bit beat for each byte-lane group k (0..3)
// that has any select bit set. Beats are issued in ascending k. Read data is reassembled
// into the matching 128-bit lanes. The request then gets exactly one s_ack_o or s_err_o pulse.
// A watchdog aborts a beat that stalls for TIMEOUT cycles. Setting TIMEOUT to 0 disables it.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   s_cyc_i .. s_dat_i        128-bit slave-side request from the MPU
//   s_ack_o, s_err_o, s_dat_o completion and error pulses, read data (all registered)
//   m_cyc_o .. m_dat_o        32-bit master-side beat (all registered)
//   m_ack_i, m_err_i, m_dat_i beat response from the peripheral interconnect
module any1_wb_dnsize #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_cyc_i,
    input  logic         s_stb_i,
    input  logic         s_we_i,
    input  logic [15:0]  s_sel_i,
    input  logic [31:0]  s_adr_i,
    input  logic [127:0] s_dat_i,
    output logic         s_ack_o,
    output logic         s_err_o,
    output logic [127:0] s_dat_o,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [3:0]   m_sel_o,
    output logic [31:0]  m_adr_o,
    output logic [31:0]  m_dat_o,
    input  logic         m_ack_i,
    input  logic         m_err_i,
    input  logic [31:0]  m_dat_i
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StBeat, StAck, StErr, StWait} state_e;

    state_e         state_q, state_d;
    logic [27:0]    adr_q, adr_d;
    logic [15:0]    sel_q, sel_d;
    logic [127:0]   dat_q, dat_d;
    logic [127:0]   buf_q, buf_d;
    logic [1:0]     k_q, k_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           s_ack_q, s_ack_d;
    logic           s_err_q, s_err_d;
    logic [127:0]   s_dat_q, s_dat_d;
    logic           m_cyc_q, m_cyc_d;
    logic           m_stb_q, m_stb_d;
    logic           m_we_q, m_we_d;
    logic [3:0]     m_sel_q, m_sel_d;
    logic [31:0]    m_adr_q, m_adr_d;
    logic [31:0]    m_dat_q, m_dat_d;

    logic [2:0]     grp_first, grp_next;
    logic [127:0]   buf_upd;
    logic           timeout_hit;

    // Address bits [3:0] select nothing: beats are addressed by lane group.
    logic unused_adr;
    assign unused_adr = ^s_adr_i[3:0];

    // Lowest active lane group at or above start; 4 means none remain.
    function automatic logic [2:0] next_grp(input logic [15:0] sel, input logic [2:0] start);
        logic [2:0] res;
        res = 3'd4;
        for (int j = 3; j >= 0; j--) begin
            if (j >= int'(start) && sel[4*j +: 4] != 4'h0) begin
                res = 3'(j);
            end
        end
        return res;
    endfunction

    always_comb begin
        grp_first = next_grp(s_sel_i, 3'd0);
        grp_next  = next_grp(sel_q, {1'b0, k_q} + 3'd1);

        buf_upd = buf_q;
        buf_upd[{k_q, 5'd0} +: 32] = m_dat_i;

        // Fires at the end of the TIMEOUT-th stalled BEAT cycle.
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

        state_d = state_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        buf_d   = buf_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;
        s_dat_d = s_dat_q;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_we_d  = m_we_q;
        m_sel_d = m_sel_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;

        unique case (state_q)
            StIdle: begin
                if (s_cyc_i && s_stb_i) begin
                    adr_d  = s_adr_i[31:4];
                    sel_d  = s_sel_i;
                    dat_d  = s_dat_i;
                    buf_d  = '0;
                    m_we_d = s_we_i;
                    if (grp_first[2]) begin
                        // Empty select: complete at once; a read returns all zeros.
                        s_ack_d = 1'b1;
                        if (!s_we_i) begin
                            s_dat_d = '0;
                        end
                        state_d = StAck;
                    end else begin
                        k_d     = grp_first[1:0];
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_sel_d = s_sel_i[{grp_first[1:0], 2'b00} +: 4];
                        m_adr_d = {s_adr_i[31:4], grp_first[1:0], 2'b00};
                        m_dat_d = s_dat_i[{grp_first[1:0], 5'd0} +: 32];
                        cnt_d   = '0;
                        state_d = StBeat;
                    end
                end
            end
            StBeat: begin
                if (!s_cyc_i) begin
                    // Master abandoned the cycle: drop silently, no ack or error.
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    state_d = StIdle;
                end else if (m_err_i || (!m_ack_i && timeout_hit)) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    s_err_d = 1'b1;
                    state_d = StErr;
                end else if (m_ack_i) begin
                    cnt_d = '0;
                    if (!m_we_q) begin
                        buf_d = buf_upd;
                    end
                    if (!grp_next[2]) begin
                        k_d     = grp_next[1:0];
                        m_sel_d = sel_q[{grp_next[1:0], 2'b00} +: 4];
                        m_adr_d = {adr_q, grp_next[1:0], 2'b00};
                        m_dat_d = dat_q[{grp_next[1:0], 5'd0} +: 32];
                    end else begin
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                        s_ack_d = 1'b1;
                        if (!m_we_q) begin
                            s_dat_d = buf_upd;
                        end
                        state_d = StAck;
                    end
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAck:   state_d = StWait;
            StErr:   state_d = StWait;
            // Hold off until the strobe drops so a held request is not taken twice.
            StWait: begin
                if (!s_stb_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            buf_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            s_dat_q <= '0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            buf_q   <= buf_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_dat_q <= s_dat_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_sel_q <= m_sel_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = s_dat_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_any1_wb_dnsize.sv
// Directed self-checking bench for any1_wb_dnsize (TIMEOUT=8).
module tb_any1_wb_dnsize;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
    logic [15:0]  s_sel_i = '0;
    logic [31:0]  s_adr_i = '0;
    logic [127:0] s_dat_i = '0;
    logic         s_ack_o, s_err_o;
    logic [127:0] s_dat_o;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_o;
    logic         m_ack_i, m_err_i;
    logic [31:0]  m_dat_i;

    // Peripheral model: zero-wait ack when enabled, optional error on one lane group.
    logic         ack_en = 1'b1, err_en = 1'b0;
    logic [1:0]   err_k = 2'd0;
    logic [31:0]  rd_mem [4];

    assign m_ack_i = ack_en & m_cyc_o & m_stb_o;
    assign m_err_i = err_en & m_cyc_o & m_stb_o & (m_adr_o[3:2] == err_k);
    assign m_dat_i = rd_mem[m_adr_o[3:2]];

    always #5 clk_i = ~clk_i;

    any1_wb_dnsize #(.TIMEOUT(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_sel_i (s_sel_i),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_ack_o (s_ack_o),
        .s_err_o (s_err_o),
        .s_dat_o (s_dat_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i),
        .m_dat_i (m_dat_i)
    );

    int checks = 0;
    int failures = 0;

    int nbeats, t_done, acks, errs, act;
    logic [31:0] b_adr [8];
    logic [31:0] b_dat [8];
    logic [3:0]  b_sel [8];
    logic        b_we  [8];
    logic [127:0] prev_dat;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; n is the cycle number after capture (0 = post-completion window).
    task automatic sample(input int n);
        if (m_cyc_o && m_stb_o) act++;
        if (m_cyc_o && m_stb_o && m_ack_i && nbeats < 8) begin
            b_adr[nbeats] = m_adr_o;
            b_dat[nbeats] = m_dat_o;
            b_sel[nbeats] = m_sel_o;
            b_we[nbeats]  = m_we_o;
            nbeats++;
        end
        if (s_ack_o) acks++;
        if (s_err_o) errs++;
        if ((s_ack_o || s_err_o) && t_done == 0 && n != 0) t_done = n;
    endtask

    // Caller is at a negedge. Capture happens at the next posedge.
    task automatic run_req(input logic we, input logic [15:0] sel, input logic [31:0] adr,
                           input logic [127:0] dat, input int budget, input bit hold);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
        s_sel_i = sel; s_adr_i = adr; s_dat_i = dat;
        nbeats = 0; t_done = 0; acks = 0; errs = 0; act = 0;
        @(posedge clk_i);
        for (int n = 1; n <= budget && t_done == 0; n++) begin
            @(negedge clk_i);
            sample(n);
        end
        if (!hold) begin
            s_cyc_i = 1'b0; s_stb_i = 1'b0;
            repeat (2) begin
                @(negedge clk_i);
                sample(0);
            end
        end
    endtask

    initial begin
        rd_mem[0] = 32'h1111_1111; rd_mem[1] = 32'h2222_2222;
        rd_mem[2] = 32'h3333_3333; rd_mem[3] = 32'h4444_4444;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_m_cyc", m_cyc_o, 0);
        check("rst_m_stb", m_stb_o, 0);
        check("rst_s_ack", s_ack_o, 0);
        check("rst_s_dat", s_dat_o, 0);
        check("rst_m_adr", m_adr_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Full-width read, zero-wait peripheral
        run_req(1'b0, 16'hFFFF, 32'hFFDC_0010, '0, 20, 1'b0);
        check("rd4_beats", nbeats, 4);
        check("rd4_adr0", b_adr[0], 32'hFFDC_0010);
        check("rd4_adr1", b_adr[1], 32'hFFDC_0014);
        check("rd4_adr2", b_adr[2], 32'hFFDC_0018);
        check("rd4_adr3", b_adr[3], 32'hFFDC_001C);
        check("rd4_sel", {b_sel[0], b_sel[1], b_sel[2], b_sel[3]}, 16'hFFFF);
        check("rd4_we", b_we[0], 0);
        check("rd4_cycle", t_done, 5);
        check("rd4_acks", acks, 1);
        check("rd4_errs", errs, 0);
        check("rd4_dat", s_dat_o, 128'h44444444_33333333_22222222_11111111);

        // Sparse write: groups 0 and 2 only
        run_req(1'b1, 16'h0F0F, 32'h0000_1234,
                128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 20, 1'b0);
        check("wr_beats", nbeats, 2);
        check("wr_adr0", b_adr[0], 32'h0000_1230);
        check("wr_dat0", b_dat[0], 32'hA0A0_A0A0);
        check("wr_adr1", b_adr[1], 32'h0000_1238);
        check("wr_dat1", b_dat[1], 32'hA2A2_A2A2);
        check("wr_we", {b_we[0], b_we[1]}, 2'b11);
        check("wr_acks", acks, 1);
        check("wr_cycle", t_done, 3);
        check("wr_sdat_kept", s_dat_o, 128'h44444444_33333333_22222222_11111111);

        // Single byte read in group 2
        rd_mem[2] = 32'hCAFE_BABE;
        run_req(1'b0, 16'h0200, 32'h4000_0000, '0, 20, 1'b0);
        check("byte_beats", nbeats, 1);
        check("byte_adr", b_adr[0], 32'h4000_0008);
        check("byte_sel", b_sel[0], 4'h2);
        check("byte_dat", s_dat_o, 128'h00000000_CAFEBABE_00000000_00000000);
        check("byte_acks", acks, 1);

        // Error on 2nd of 4 beats (ack also high: error must win)
        prev_dat = 128'h00000000_CAFEBABE_00000000_00000000;
        err_en = 1'b1; err_k = 2'd1;
        run_req(1'b0, 16'hFFFF, 32'h0000_0100, '0, 20, 1'b0);
        err_en = 1'b0;
        check("err_beats", nbeats, 2);
        check("err_errs", errs, 1);
        check("err_acks", acks, 0);
        check("err_cycle", t_done, 3);
        check("err_sdat_kept", s_dat_o, prev_dat);

        // Empty select
        run_req(1'b0, 16'h0000, 32'h0000_0200, '0, 20, 1'b0);
        check("sel0_act", act, 0);
        check("sel0_cycle", t_done, 1);
        check("sel0_acks", acks, 1);
        check("sel0_dat", s_dat_o, 0);

        // Watchdog: peripheral never answers, strobe held afterwards
        ack_en = 1'b0;
        run_req(1'b0, 16'h000F, 32'h0000_0300, '0, 20, 1'b1);
        check("to_cycle", t_done, 9);
        check("to_act", act, 8);
        check("to_errs", errs, 1);
        act = 0; acks = 0; errs = 0;
        repeat (5) begin
            @(negedge clk_i);
            sample(0);
        end
        check("hold_no_capture", act, 0);
        check("hold_no_pulse", acks + errs, 0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(negedge clk_i);

        // Abort: s_cyc drops in the same cycle as a beat ack
        ack_en = 1'b1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
        s_sel_i = 16'hFFFF; s_adr_i = 32'h0000_0400;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_pre_cyc", m_cyc_o, 1);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        act = 0; acks = 0; errs = 0;
        repeat (3) begin
            @(negedge clk_i);
            sample(0);
        end
        check("abort_act", act, 0);
        check("abort_pulses", acks + errs, 0);

        // Asynchronous reset mid-beat
        ack_en = 1'b0;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        s_sel_i = 16'hF000; s_adr_i = 32'h0000_0500;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_pre_adr", m_adr_o, 32'h0000_050C);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_cyc", m_cyc_o, 0);
        check("mid_rst_stb", m_stb_o, 0);
        check("mid_rst_adr", m_adr_o, 0);
        check("mid_rst_sdat", s_dat_o, 0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
